mem_port_arbiter: RTL

- Sequences and shares the single-port 8-bit RAM block (address/data/wr/cs/o interface, active-low cs, write on rising Clock) between two requesters.
- Requester A is the fetch side; requester B is the load/store side.
- Performs round-robin arbitration and a req/ack handshake per transaction.
- Owns all RAM control signals. Flags out-of-range addresses instead of aliasing them into the array.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a fetch port (A) and a load/store port (B).
// One transaction per three cycles: ACCESS/ERROR, DONE (ack), then back to IDLE.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_o,
    output logic              busy,
    output logic [15:0]       txn_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // owner_b_q: current transaction belongs to B; last_b_q: B won the previous grant
    logic owner_b_q, owner_b_d;
    logic last_b_q, last_b_d;

    logic [ADDR_W-1:0] mem_address_d;
    logic [DATA_W-1:0] mem_data_d;
    logic              mem_wr_d;
    logic              mem_cs_d;
    logic              a_ack_d, b_ack_d;
    logic              a_err_d, b_err_d;
    logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
    logic              busy_d;
    logic [CNT_W-1:0]  txn_count_d;

    // Winner selection: B wins when alone, or on a tie when A had the last grant
    logic              sel_b_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic              sel_wr_c;
    logic              sel_in_range_c;

    assign sel_b_c        = b_req && (!a_req || !last_b_q);
    assign sel_addr_c     = sel_b_c ? b_addr  : a_addr;
    assign sel_wdata_c    = sel_b_c ? b_wdata : a_wdata;
    assign sel_wr_c       = sel_b_c ? b_wr    : a_wr;
    assign sel_in_range_c = {1'b0, sel_addr_c} < DEPTH_L;

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        owner_b_d     = owner_b_q;
        last_b_d      = last_b_q;
        mem_address_d = mem_address;
        mem_data_d    = mem_data;
        mem_wr_d      = mem_wr;
        mem_cs_d      = 1'b1;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        a_err_d       = 1'b0;
        b_err_d       = 1'b0;
        a_rdata_d     = a_rdata;
        b_rdata_d     = b_rdata;
        txn_count_d   = txn_count;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    owner_b_d     = sel_b_c;
                    last_b_d      = sel_b_c;
                    mem_address_d = sel_addr_c;
                    mem_data_d    = sel_wdata_c;
                    if (sel_in_range_c) begin
                        state_d  = ACCESS;
                        mem_wr_d = sel_wr_c;
                        mem_cs_d = 1'b0;
                    end else begin
                        state_d  = ERROR;
                        mem_wr_d = 1'b0;
                    end
                end
            end
            ACCESS: begin
                state_d  = DONE;
                mem_wr_d = 1'b0;
                if (owner_b_q) begin
                    b_ack_d = 1'b1;
                    if (!mem_wr) b_rdata_d = mem_o;
                end else begin
                    a_ack_d = 1'b1;
                    if (!mem_wr) a_rdata_d = mem_o;
                end
            end
            ERROR: begin
                state_d  = DONE;
                mem_wr_d = 1'b0;
                if (owner_b_q) begin
                    b_ack_d   = 1'b1;
                    b_err_d   = 1'b1;
                    b_rdata_d = '0;
                end else begin
                    a_ack_d   = 1'b1;
                    a_err_d   = 1'b1;
                    a_rdata_d = '0;
                end
            end
            DONE: begin
                state_d     = IDLE;
                txn_count_d = txn_count + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= IDLE;
            owner_b_q   <= 1'b0;
            last_b_q    <= 1'b1;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wr      <= 1'b0;
            mem_cs      <= 1'b1;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_err       <= 1'b0;
            b_err       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            busy        <= 1'b0;
            txn_count   <= '0;
        end else begin
            state_q     <= state_d;
            owner_b_q   <= owner_b_d;
            last_b_q    <= last_b_d;
            mem_address <= mem_address_d;
            mem_data    <= mem_data_d;
            mem_wr      <= mem_wr_d;
            mem_cs      <= mem_cs_d;
            a_ack       <= a_ack_d;
            b_ack       <= b_ack_d;
            a_err       <= a_err_d;
            b_err       <= b_err_d;
            a_rdata     <= a_rdata_d;
            b_rdata     <= b_rdata_d;
            busy        <= busy_d;
            txn_count   <= txn_count_d;
        end
    end

endmodule
